// File: rtl/serial_sync_ctrl.sv
// Bit-serial comma hunter: locks byte/frame phase, confirms recurring commas, emits aligned bytes.
// One cycle from a byte's last bit to DATA_OUT/BYTE_VALID. There is no backpressure: the stream is consumed every cycle.
module serial_sync_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         FRAME_LEN  = 4,
  parameter int         ACQ_COUNT  = 2,
  parameter int         LOSS_COUNT = 2,
  parameter int         ERRW       = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            DATA_IN,
  output logic [7:0]      DATA_OUT,
  output logic            BYTE_VALID,
  output logic            SOF,
  output logic            SYNC,
  output logic [ERRW-1:0] ERR_COUNT
);

  localparam int BCW = $clog2(FRAME_LEN);
  localparam int GCW = $clog2(ACQ_COUNT);
  localparam int BDW = $clog2(LOSS_COUNT + 1);

  localparam logic [BCW-1:0] LAST_SLOT = BCW'(FRAME_LEN - 1);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(ACQ_COUNT - 1);
  localparam logic [BDW-1:0] BAD_LAST  = BDW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  state_t         state;
  logic [6:0]     sh;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [GCW-1:0] good_cnt;
  logic [BDW-1:0] bad_cnt;

  logic [7:0]     window;
  logic           boundary;
  logic           comma_slot;
  logic           is_comma;
  logic [BCW-1:0] byte_cnt_nxt;

  assign window       = {sh, DATA_IN};
  assign boundary     = (bit_cnt == 3'd7);
  assign comma_slot   = (byte_cnt == '0);
  assign is_comma     = (window == COMMA);
  assign byte_cnt_nxt = (byte_cnt == LAST_SLOT) ? '0 : byte_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_HUNT;
      sh         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      DATA_OUT   <= '0;
      BYTE_VALID <= 1'b0;
      SOF        <= 1'b0;
      SYNC       <= 1'b0;
      ERR_COUNT  <= '0;
    end else begin
      sh         <= window[6:0];
      BYTE_VALID <= 1'b0;
      SOF        <= 1'b0;
      case (state)
        ST_HUNT: begin
          // The hunt hit itself is byte 0 of a frame, so the next boundary is slot 1.
          if (is_comma) begin
            state    <= ST_CHECK;
            bit_cnt  <= '0;
            byte_cnt <= BCW'(1);
            good_cnt <= GCW'(1);
          end
        end
        ST_CHECK: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            byte_cnt <= byte_cnt_nxt;
            if (comma_slot) begin
              if (!is_comma) begin
                state <= ST_HUNT;
              end else if (good_cnt == GOOD_LAST) begin
                state      <= ST_SYNC;
                SYNC       <= 1'b1;
                DATA_OUT   <= COMMA;
                BYTE_VALID <= 1'b1;
                SOF        <= 1'b1;
                bad_cnt    <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end
        end
        ST_SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            byte_cnt <= byte_cnt_nxt;
            if (comma_slot && !is_comma) begin
              if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
              // The byte that exhausts the loss budget is suppressed, not emitted.
              if (bad_cnt == BAD_LAST) begin
                state <= ST_HUNT;
                SYNC  <= 1'b0;
              end else begin
                bad_cnt    <= bad_cnt + 1'b1;
                DATA_OUT   <= window;
                BYTE_VALID <= 1'b1;
              end
            end else begin
              DATA_OUT   <= window;
              BYTE_VALID <= 1'b1;
              SOF        <= comma_slot;
              if (comma_slot) bad_cnt <= '0;
            end
          end
        end
        default: begin
          state <= ST_HUNT;
          SYNC  <= 1'b0;
        end
      endcase
    end
  end

endmodule
